// File: rtl/duck_flight_ctrl.sv
// Duck sprite motion/state controller: once per frame it updates position, wing flap and
// round state, resolves trigger shots against the duck box and keeps hit/escape tallies.
module duck_flight_ctrl #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned DUCK_W        = 32,
  parameter int unsigned DUCK_H        = 32,
  parameter int unsigned STEP          = 2,
  parameter int unsigned FALL_STEP     = 4,
  parameter int unsigned FLY_Y_MIN     = 40,
  parameter int unsigned GROUND_Y      = 320,
  parameter int unsigned ESCAPE_FRAMES = 600,
  parameter int unsigned HIT_PAUSE     = 30,
  parameter int unsigned FLAP_DIV      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       start,
  input  logic       shot,
  input  logic [9:0] cross_x,
  input  logic [9:0] cross_y,
  output logic [9:0] duck_x,
  output logic [9:0] duck_y,
  output logic       duck_visible,
  output logic [1:0] sprite_sel,
  output logic       dir_left,
  output logic       hit_pulse,
  output logic       escape_pulse,
  output logic [3:0] ducks_hit,
  output logic [3:0] ducks_escaped
);

  localparam int unsigned PW    = 10;
  localparam int unsigned PW1   = PW + 1;
  localparam int unsigned CW    = 10;
  localparam int unsigned NW    = 4;
  localparam int unsigned FW    = $clog2(FLAP_DIV);
  localparam int unsigned X_MAX = H_ACTIVE - DUCK_W;
  localparam int unsigned Y_MAX = GROUND_Y - DUCK_H;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESPAWN,
    S_FLY,
    S_HIT,
    S_FALL,
    S_ESCAPE
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   x_q, x_d;
  logic [PW-1:0]   y_q, y_d;
  logic            vis_q, vis_d;
  logic [1:0]      sel_q, sel_d;
  logic            left_q, left_d;
  logic            up_q, up_d;
  logic            hitp_q, hitp_d;
  logic            escp_q, escp_d;
  logic [NW-1:0]   nhit_q, nhit_d;
  logic [NW-1:0]   nesc_q, nesc_d;
  logic [CW-1:0]   fcnt_q, fcnt_d;
  logic [FW-1:0]   flap_q, flap_d;
  logic [9:0]      lfsr_q, lfsr_d;
  logic            tick_q, tick_d;

  logic            hit_c;
  logic            flap_wrap_c;
  logic [PW1-1:0]  x_inc_c;
  logic [PW1-1:0]  y_inc_c;
  logic [PW1-1:0]  y_fall_c;
  logic [PW1-1:0]  x_end_c;
  logic [PW1-1:0]  y_end_c;

  // Frame tick fires once, the cycle after the first pixel of vertical blank is seen.
  assign tick_d = (hcount == PW'(0)) && (vcount == PW'(V_ACTIVE));
  assign lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

  assign x_inc_c  = {1'b0, x_q} + PW1'(STEP);
  assign y_inc_c  = {1'b0, y_q} + PW1'(STEP);
  assign y_fall_c = {1'b0, y_q} + PW1'(FALL_STEP);
  assign x_end_c  = {1'b0, x_q} + PW1'(DUCK_W);
  assign y_end_c  = {1'b0, y_q} + PW1'(DUCK_H);

  // Box test is done one bit wider so a duck near the right edge cannot wrap.
  assign hit_c = shot && (state_q == S_FLY)
              && ({1'b0, cross_x} >= {1'b0, x_q}) && ({1'b0, cross_x} < x_end_c)
              && ({1'b0, cross_y} >= {1'b0, y_q}) && ({1'b0, cross_y} < y_end_c);

  assign flap_wrap_c = (flap_q == FW'(FLAP_DIV - 1));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vis_d   = vis_q;
    sel_d   = sel_q;
    left_d  = left_q;
    up_d    = up_q;
    hitp_d  = 1'b0;
    escp_d  = 1'b0;
    nhit_d  = nhit_q;
    nesc_d  = nesc_q;
    fcnt_d  = fcnt_q;
    flap_d  = flap_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RESPAWN;
      end

      S_RESPAWN: begin
        if (tick_q) begin
          x_d     = PW'(lfsr_q[8:0]);
          y_d     = PW'(Y_MAX);
          left_d  = lfsr_q[9];
          up_d    = 1'b1;
          vis_d   = 1'b1;
          sel_d   = 2'b00;
          fcnt_d  = '0;
          flap_d  = '0;
          state_d = S_FLY;
        end
      end

      S_FLY: begin
        // A shot landing on the tick wins: the duck freezes where it was hit.
        if (hit_c) begin
          state_d = S_HIT;
          sel_d   = 2'b10;
          hitp_d  = 1'b1;
          fcnt_d  = '0;
          if (nhit_q != '1) nhit_d = nhit_q + NW'(1);
        end else if (tick_q) begin
          if (left_q) begin
            if (x_q < PW'(STEP)) begin
              x_d    = '0;
              left_d = 1'b0;
            end else begin
              x_d = x_q - PW'(STEP);
            end
          end else if (x_inc_c > PW1'(X_MAX)) begin
            x_d    = PW'(X_MAX);
            left_d = 1'b1;
          end else begin
            x_d = x_inc_c[PW-1:0];
          end

          if (up_q) begin
            if (y_q < PW'(FLY_Y_MIN + STEP)) begin
              y_d  = PW'(FLY_Y_MIN);
              up_d = 1'b0;
            end else begin
              y_d = y_q - PW'(STEP);
            end
          end else if (y_inc_c > PW1'(Y_MAX)) begin
            y_d  = PW'(Y_MAX);
            up_d = 1'b1;
          end else begin
            y_d = y_inc_c[PW-1:0];
          end

          flap_d = flap_wrap_c ? '0 : flap_q + FW'(1);
          if (flap_wrap_c) sel_d = {1'b0, ~sel_q[0]};
          fcnt_d = fcnt_q + CW'(1);
          if (fcnt_q == CW'(ESCAPE_FRAMES - 1)) state_d = S_ESCAPE;
        end
      end

      S_HIT: begin
        if (tick_q) begin
          fcnt_d = fcnt_q + CW'(1);
          if (fcnt_q == CW'(HIT_PAUSE - 1)) begin
            state_d = S_FALL;
            sel_d   = 2'b11;
          end
        end
      end

      S_FALL: begin
        if (tick_q) begin
          if (y_fall_c >= PW1'(Y_MAX)) begin
            y_d     = PW'(Y_MAX);
            vis_d   = 1'b0;
            state_d = S_RESPAWN;
          end else begin
            y_d = y_fall_c[PW-1:0];
          end
        end
      end

      S_ESCAPE: begin
        // Climbs off the top; the tick after reaching row 0 counts the escape.
        if (tick_q) begin
          if (y_q < PW'(STEP)) begin
            y_d     = '0;
            vis_d   = 1'b0;
            escp_d  = 1'b1;
            state_d = S_RESPAWN;
            if (nesc_q != '1) nesc_d = nesc_q + NW'(1);
          end else begin
            y_d    = y_q - PW'(STEP);
            flap_d = flap_wrap_c ? '0 : flap_q + FW'(1);
            if (flap_wrap_c) sel_d = {1'b0, ~sel_q[0]};
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= PW'(Y_MAX);
      vis_q   <= 1'b0;
      sel_q   <= 2'b00;
      left_q  <= 1'b0;
      up_q    <= 1'b1;
      hitp_q  <= 1'b0;
      escp_q  <= 1'b0;
      nhit_q  <= '0;
      nesc_q  <= '0;
      fcnt_q  <= '0;
      flap_q  <= '0;
      lfsr_q  <= 10'h001;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vis_q   <= vis_d;
      sel_q   <= sel_d;
      left_q  <= left_d;
      up_q    <= up_d;
      hitp_q  <= hitp_d;
      escp_q  <= escp_d;
      nhit_q  <= nhit_d;
      nesc_q  <= nesc_d;
      fcnt_q  <= fcnt_d;
      flap_q  <= flap_d;
      lfsr_q  <= lfsr_d;
      tick_q  <= tick_d;
    end
  end

  assign duck_x        = x_q;
  assign duck_y        = y_q;
  assign duck_visible  = vis_q;
  assign sprite_sel    = sel_q;
  assign dir_left      = left_q;
  assign hit_pulse     = hitp_q;
  assign escape_pulse  = escp_q;
  assign ducks_hit     = nhit_q;
  assign ducks_escaped = nesc_q;

endmodule

// File: doc/duck_flight_ctrl.md
Name: duck_flight_ctrl

Overview:
- Per-frame motion/state controller for the duck sprite; sequences the duck drawer by supplying position, visibility and sprite-frame select.
- Takes the VGA scan counters (hcount/vcount) and updates duck state only once per frame, at the start of vertical blank, so the drawer sees stable coordinates for a whole frame.
- Also resolves trigger shots against the duck box and counts hits/escapes.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines; frame tick at vcount==V_ACTIVE
- DUCK_W, 32, sprite width in pixels
- DUCK_H, 32, sprite height in pixels
- STEP, 2, flight pixels per frame per axis
- FALL_STEP, 4, fall pixels per frame
- FLY_Y_MIN, 40, top of flight band
- GROUND_Y, 320, ground line; duck bottom never below it
- ESCAPE_FRAMES, 600, FLY frames before duck escapes
- HIT_PAUSE, 30, frames frozen after hit
- FLAP_DIV, 8, frames per wing-flap toggle

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  asynchronous, active-high reset
- hcount  in  10  current pixel column
- vcount  in  10  current line
- start  in  1  one-cycle pulse, begins round from IDLE
- shot  in  1  one-cycle trigger pulse
- cross_x  in  10  crosshair x at shot
- cross_y  in  10  crosshair y at shot
- duck_x  out  10  sprite left edge
- duck_y  out  10  sprite top edge
- duck_visible  out  1  drawer enable
- sprite_sel  out  2  00 flap-up, 01 flap-down, 10 hit, 11 falling
- dir_left  out  1  1 = flying left (drawer mirrors)
- hit_pulse  out  1  one cycle on confirmed hit
- escape_pulse  out  1  one cycle when duck leaves screen
- ducks_hit  out  4  saturating hit count
- ducks_escaped  out  4  saturating escape count

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: state IDLE, duck_x=0, duck_y=GROUND_Y-DUCK_H (288), duck_visible=0, sprite_sel=00, dir_left=0, dir_up=1, pulses 0, counters 0, frame counter 0, LFSR=10'h001.
- frame_tick: registered one-cycle pulse, asserted the cycle after hcount==0 && vcount==V_ACTIVE is sampled. Position, flap and frame counters change only on frame_tick.
- LFSR: 10-bit, x^10+x^7+1, advances every clk, never reaches 0.
- IDLE: start -> RESPAWN next cycle. start is ignored in all other states.
- RESPAWN, on frame_tick:
  - duck_x=lfsr[8:0] (0..511), duck_y=288, dir_left=lfsr[9], dir_up=1.
  - duck_visible=1, frame counter=0, go FLY.
- FLY, per tick:
  - x moves ±STEP; y moves ±STEP.
  - Right edge: if duck_x+STEP > H_ACTIVE-DUCK_W (608), clamp to 608 and set dir_left=1. Left edge: if duck_x < STEP, clamp to 0 and set dir_left=0.
  - y bounces the same way within [FLY_Y_MIN, GROUND_Y-DUCK_H].
  - sprite_sel toggles 00/01 every FLAP_DIV ticks.
  - Frame counter reaching ESCAPE_FRAMES -> ESCAPE.
- Shot/hit:
  - A shot in FLY is a hit when duck_x<=cross_x<duck_x+DUCK_W and duck_y<=cross_y<duck_y+DUCK_H (11-bit compare, no wrap).
  - Hit effects: HIT next cycle, sprite_sel=10, hit_pulse next cycle, ducks_hit+1 (saturates at 15).
  - Hit beats movement when shot and frame_tick coincide: no move that tick.
  - Shots in any other state are ignored.
- HIT: position frozen for HIT_PAUSE ticks -> FALL with sprite_sel=11.
- FALL, per tick: y+=FALL_STEP. When y >= 288, clamp to 288, duck_visible=0, go RESPAWN.
- ESCAPE, per tick: x frozen, y-=STEP, flap continues. If y < STEP, set y=0, duck_visible=0, pulse escape_pulse, ducks_escaped+1 (saturating), go RESPAWN.
- A round never returns to IDLE except via reset. Asserting reset mid-flight returns to reset values asynchronously.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset held 2 cycles, released; scan counters run 0..640/0..480 -> frame_tick every 641*481 cycles; outputs hold reset values until start.
- start, then 1 frame -> duck_visible=1, duck_y=288, duck_x=lfsr[8:0]. Each following tick: y decreases by 2, x changes by 2.
- Force FLY at duck_x=607, right-moving -> next tick duck_x=608, dir_left=1; next tick 606.
- Shot with cross=(duck_x+5, duck_y+31) -> hit_pulse 1 cycle, ducks_hit=1, sprite_sel=10, position frozen 30 ticks. Falling at 4/tick to y=288 -> visible=0, then respawn. Shot at duck_x+32 -> no hit.
- No shots for 600 ticks -> ESCAPE; y drops to 0 -> escape_pulse, ducks_escaped=1. Repeat 16 rounds -> saturates at 15.
- Shot coincident with frame_tick -> hit, no movement. Reset asserted during FALL -> immediate reset values.
